// File: rtl/exgcd_arbiter.sv
// exgcd_arbiter: round-robin front end that shares one extended-GCD /
// modular-inverse engine among 2**IDW requesters. Accepts one job at a
// time, screens zero operands, starts the engine, bounds the wait with a
// timeout and returns gcd / inverse / error tagged with the requester id.
module exgcd_arbiter #(
    parameter int unsigned IDW     = 2,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [(1<<IDW)-1:0]        req_valid,
    input  logic [(1<<IDW)*W-1:0]      req_a,
    input  logic [(1<<IDW)*W-1:0]      req_b,
    output logic [(1<<IDW)-1:0]        req_ready,
    output logic                       eng_start,
    output logic [W-1:0]               eng_a,
    output logic [W-1:0]               eng_b,
    input  logic                       eng_done,
    input  logic [W-1:0]               eng_gcd,
    input  logic [W-1:0]               eng_inv,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [W-1:0]               rsp_gcd,
    output logic [W-1:0]               rsp_inv,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int unsigned NREQ = 1 << IDW;
    localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Control state
    logic [1:0]     r_state;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_id;
    logic [TW-1:0]  r_timer;

    // Registered outputs
    logic [W-1:0]   r_eng_a;
    logic [W-1:0]   r_eng_b;
    logic           r_eng_start;
    logic           r_busy;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_gcd;
    logic [W-1:0]   r_rsp_inv;
    logic           r_rsp_err;

    // Combinational helpers
    logic [1:0]     w_next;
    logic [IDW-1:0] w_sel;
    logic           w_found;
    logic           w_accept;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic           w_zero;
    logic           w_timeout;

    // Round-robin pick: first valid index scanning upward from last+1, with wrap
    always_comb begin : sel_scan
        logic [IDW-1:0] v_idx;
        w_sel   = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            v_idx = r_last + IDW'(k);
            if (!w_found && req_valid[v_idx]) begin
                w_sel   = v_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_sel_a   = req_a[32'(w_sel) * W +: W];
    assign w_sel_b   = req_b[32'(w_sel) * W +: W];
    assign w_zero    = (w_sel_a == '0) || (w_sel_b == '0);
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    // One-hot accept strobe, only while idle and something is pending
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status strobes follow the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_eng_start <= (w_next == S_ISSUE);
            r_busy      <= (w_next != S_IDLE);
            r_rsp_valid <= (w_next == S_RESP);
        end
    end

    // Job latch, timer and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= IDW'(NREQ - 1);
            r_id      <= '0;
            r_timer   <= '0;
            r_eng_a   <= '0;
            r_eng_b   <= '0;
            r_rsp_id  <= '0;
            r_rsp_gcd <= '0;
            r_rsp_inv <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_sel;
                        r_eng_a <= w_sel_a;
                        r_eng_b <= w_sel_b;
                        if (w_zero) begin
                            // Degenerate operand: answer directly, engine untouched
                            r_rsp_id  <= w_sel;
                            r_rsp_gcd <= w_sel_a | w_sel_b;
                            r_rsp_inv <= '0;
                            r_rsp_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        // Done beats a simultaneous timeout
                        r_rsp_id  <= r_id;
                        r_rsp_gcd <= eng_gcd;
                        if (eng_gcd == W'(1)) begin
                            r_rsp_inv <= eng_inv;
                            r_rsp_err <= 1'b0;
                        end else begin
                            r_rsp_inv <= '0;
                            r_rsp_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_rsp_id  <= r_id;
                        r_rsp_gcd <= '0;
                        r_rsp_inv <= '0;
                        r_rsp_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_last <= r_rsp_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_a     = r_eng_a;
    assign eng_b     = r_eng_b;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_gcd   = r_rsp_gcd;
    assign rsp_inv   = r_rsp_inv;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_exgcd_arbiter.sv
// Bench for exgcd_arbiter: behavioural engine model, response scoreboard,
// directed sequence covering latency, zero operands, round-robin order,
// done-at-timeout boundary, timeout with backpressure and mid-job reset.
module tb_exgcd_arbiter;

    localparam int unsigned IDW  = 2;
    localparam int unsigned W    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TOUT = 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   gcd;
        logic [W-1:0]   inv;
        logic           err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 eng_start;
    logic [W-1:0]         eng_a;
    logic [W-1:0]         eng_b;
    logic                 eng_done;
    logic [W-1:0]         eng_gcd;
    logic [W-1:0]         eng_inv;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_gcd;
    logic [W-1:0]         rsp_inv;
    logic                 rsp_err;
    logic                 busy;

    exgcd_arbiter #(.IDW(IDW), .W(W), .TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd),
        .eng_inv   (eng_inv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .rsp_inv   (rsp_inv),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   acc_id[$];
    int   acc_t[$];

    // engine model controls / observations
    int eng_dly  = 5;
    bit eng_hang = 1'b0;
    int t_start  = -1;
    int t_done   = -1;
    int n_start  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int ref_inv(input int a, input int b);
        for (int x = 1; x < b; x++) begin
            if (((a * x) % b) == 1) return x;
        end
        return 0;
    endfunction

    task automatic push_exp(input int id, input int a, input int b, input bit to);
        exp_t e;
        int   g;
        e.id = IDW'(id);
        if (to) begin
            e.gcd = '0; e.inv = '0; e.err = 1'b1;
        end else if (a == 0 || b == 0) begin
            e.gcd = W'(a | b); e.inv = '0; e.err = 1'b1;
        end else begin
            g     = ref_gcd(a, b);
            e.gcd = W'(g);
            e.err = (g != 1);
            e.inv = (g == 1) ? W'(ref_inv(a, b)) : '0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after acceptance
    task automatic do_req(input int id, input int a, input int b, output int t);
        t = -1;
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        req_valid[id]    = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (req_ready[id]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) chk("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int k = 0; k < 150; k++) begin
            #1;
            if (rsp_valid) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_acc(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (acc_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_count_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    // Engine model: answers eng_dly cycles after the start pulse
    initial begin
        int ea;
        int eb;
        int g;
        eng_done = 1'b0;
        eng_gcd  = 8'hA5;
        eng_inv  = 8'h5A;
        forever begin
            @(negedge clk);
            #1;
            if (eng_start === 1'b1) begin
                t_start = cyc;
                n_start++;
                ea = int'(eng_a);
                eb = int'(eng_b);
                if (!eng_hang) begin
                    repeat (eng_dly) @(negedge clk);
                    g        = ref_gcd(ea, eb);
                    eng_gcd  = W'(g);
                    eng_inv  = (g == 1) ? W'(ref_inv(ea, eb)) : 8'h77;
                    eng_done = 1'b1;
                    t_done   = cyc;
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_gcd  = 8'hA5;
                    eng_inv  = 8'h5A;
                end
            end
        end
    end

    // Monitor: accept log, one-hot pulse check, scoreboard on response handshake
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (|req_ready) begin
                    chk("ready_onehot", 32'($onehot(req_ready)), 1);
                    chk("ready_pulse", 32'(prev), 0);
                    for (int i = 0; i < NREQ; i++) begin
                        if (req_ready[i]) begin
                            acc_id.push_back(i);
                            acc_t.push_back(cyc);
                        end
                    end
                end
                prev = |req_ready;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id",  32'(rsp_id),  32'(e.id));
                        chk("rsp_gcd", 32'(rsp_gcd), 32'(e.gcd));
                        chk("rsp_inv", 32'(rsp_inv), 32'(e.inv));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int tr;
        int s0;
        int td0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_a",     32'(eng_a), 0);
        chk("rst_eng_b",     32'(eng_b), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_rsp_gcd",   32'(rsp_gcd), 0);
        chk("rst_rsp_inv",   32'(rsp_inv), 0);
        chk("rst_rsp_err",   32'(rsp_err), 0);
        chk("rst_busy",      32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single coprime request, engine done 5 cycles after start
        eng_dly = 5;
        push_exp(0, 3, 7, 1'b0);
        @(negedge clk);
        do_req(0, 3, 7, t);
        #1;
        chk("t1_eng_start", 32'(eng_start), 1);
        chk("t1_eng_a",     32'(eng_a), 3);
        chk("t1_eng_b",     32'(eng_b), 7);
        chk("t1_busy",      32'(busy), 1);
        chk("t1_ready_low", 32'(req_ready), 0);
        wait_rsp(tr);
        chk("t1_start_lat", t_start, t + 1);
        chk("t1_rsp_after_done", tr, t_done + 1);
        chk("t1_rsp_abs", tr, t + 7);
        drain();

        // non-coprime operands
        push_exp(1, 6, 9, 1'b0);
        @(negedge clk);
        do_req(1, 6, 9, t);
        wait_rsp(tr);
        drain();

        // zero operand: immediate error response, no engine start
        s0 = n_start;
        push_exp(3, 0, 5, 1'b0);
        @(negedge clk);
        do_req(3, 0, 5, t);
        #1;
        chk("t3_rsp_valid_t1", 32'(rsp_valid), 1);
        chk("t3_no_start",     32'(eng_start), 0);
        chk("t3_busy",         32'(busy), 1);
        drain();
        chk("t3_start_count", n_start, s0);

        // round-robin with all requesters pending
        eng_dly = 1;
        acc_id.delete();
        acc_t.delete();
        push_exp(0, 5, 12, 1'b0);
        push_exp(1, 4, 10, 1'b0);
        push_exp(2, 7, 11, 1'b0);
        push_exp(3, 0, 9, 1'b0);
        push_exp(0, 5, 12, 1'b0);
        @(negedge clk);
        req_a = {8'd0, 8'd7, 8'd4, 8'd5};
        req_b = {8'd9, 8'd11, 8'd10, 8'd12};
        req_valid = 4'hF;
        wait_acc(5);
        req_valid = '0;
        chk("rr_order0", acc_id[0], 0);
        chk("rr_order1", acc_id[1], 1);
        chk("rr_order2", acc_id[2], 2);
        chk("rr_order3", acc_id[3], 3);
        chk("rr_order4", acc_id[4], 0);
        chk("rr_min_period", acc_t[1] - acc_t[0], 4);
        drain();

        // done in the last WAIT cycle still wins over timeout
        eng_dly = 8;
        push_exp(1, 5, 7, 1'b0);
        @(negedge clk);
        do_req(1, 5, 7, t);
        wait_rsp(tr);
        chk("t5_done_cycle", t_done, t + 9);
        chk("t5_rsp_cycle", tr, t + 10);
        drain();

        // timeout, then backpressure with another request pending
        eng_hang  = 1'b1;
        rsp_ready = 1'b0;
        acc_id.delete();
        push_exp(1, 3, 5, 1'b1);
        push_exp(2, 8, 15, 1'b0);
        @(negedge clk);
        do_req(1, 3, 5, t);
        req_a[2*W +: W] = 8'd8;
        req_b[2*W +: W] = 8'd15;
        req_valid[2]    = 1'b1;
        wait_rsp(tr);
        chk("t6_timeout_cycle", tr, t + 2 + int'(TOUT));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("t6_hold_valid", 32'(rsp_valid), 1);
            chk("t6_hold_id",    32'(rsp_id), 1);
            chk("t6_hold_gcd",   32'(rsp_gcd), 0);
            chk("t6_hold_inv",   32'(rsp_inv), 0);
            chk("t6_hold_err",   32'(rsp_err), 1);
            chk("t6_no_accept",  32'(req_ready), 0);
        end
        @(negedge clk);
        eng_hang  = 1'b0;
        rsp_ready = 1'b1;
        wait_acc(2);
        req_valid[2] = 1'b0;
        chk("t6_pending_served", acc_id[1], 2);
        drain();

        // reset during WAIT, then a stale done from the aborted job
        eng_dly = 20;
        @(negedge clk);
        do_req(2, 3, 7, t);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_busy",      32'(busy), 0);
        chk("t7_eng_start", 32'(eng_start), 0);
        chk("t7_eng_a",     32'(eng_a), 0);
        chk("t7_eng_b",     32'(eng_b), 0);
        chk("t7_rsp_valid", 32'(rsp_valid), 0);
        chk("t7_rsp_id",    32'(rsp_id), 0);
        chk("t7_rsp_gcd",   32'(rsp_gcd), 0);
        chk("t7_rsp_inv",   32'(rsp_inv), 0);
        chk("t7_rsp_err",   32'(rsp_err), 0);
        chk("t7_req_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        td0 = t_done;
        repeat (25) @(negedge clk);
        #1;
        chk("t7_stale_done_seen", 32'(t_done > td0), 1);
        chk("t7_no_rsp", 32'(rsp_valid), 0);
        chk("t7_idle",   32'(busy), 0);

        // after reset requester 0 has priority again
        eng_dly = 2;
        acc_id.delete();
        push_exp(0, 2, 9, 1'b0);
        push_exp(3, 9, 6, 1'b0);
        @(negedge clk);
        req_a[0*W +: W] = 8'd2;
        req_b[0*W +: W] = 8'd9;
        req_a[3*W +: W] = 8'd9;
        req_b[3*W +: W] = 8'd6;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_acc(1);
        req_valid[0] = 1'b0;
        wait_acc(2);
        req_valid[3] = 1'b0;
        chk("t8_first",  acc_id[0], 0);
        chk("t8_second", acc_id[1], 3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exgcd_arbiter.md
# exgcd_arbiter

Round-robin arbiter and sequencer that shares one extended-GCD / modular-inverse engine among 2**IDW requesters. It accepts operand pairs over per-requester valid/ready handshakes, screens out degenerate operands, and issues a one-cycle start to the engine. It then waits for engine completion with a timeout and returns gcd, inverse and error status tagged with the requester id. It sits between the client blocks and the single exgcd datapath instance.

## Interface
- IDW, 2: requester id width; NREQ = 2**IDW requesters.
- W, 8: operand/result width.
- TIMEOUT, 64: maximum WAIT cycles before abort (≥2).

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*W  operand a; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  operand b (modulus); same packing.
- req_ready  out  NREQ  one-hot accept strobe; at most one bit high per cycle.
- eng_start  out  1  one-cycle engine start pulse.
- eng_a  out  W  latched a; stable from ISSUE until return to IDLE.
- eng_b  out  W  latched b; same.
- eng_done  in  1  engine result valid pulse.
- eng_gcd  in  W  engine gcd, sampled when eng_done is high.
- eng_inv  in  W  engine a^-1 mod b, sampled when eng_done is high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  id of the served requester.
- rsp_gcd  out  W  result gcd.
- rsp_inv  out  W  result inverse; 0 whenever rsp_err is high.
- rsp_err  out  1  no inverse: zero operand, gcd≠1, or timeout.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Selection: if any req_valid bit is high, select the first valid index scanning upward, with wrap, from last+1.
  - Acceptance: in the same cycle, assert req_ready[sel] combinationally, latch a, b and id.
  - Routing: if a==0 or b==0, go to RESP with rsp_err=1, rsp_gcd=a|b, rsp_inv=0 and no engine start. Otherwise go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - On eng_done: capture eng_gcd. If eng_gcd==1, capture rsp_inv=eng_inv and rsp_err=0; otherwise rsp_inv=0 and rsp_err=1. Go to RESP.
  - Timeout: otherwise the timer increments. When the timer==TIMEOUT-1 with no done, set rsp_gcd=0, rsp_inv=0, rsp_err=1 and go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* outputs stay stable until rsp_valid && rsp_ready.
  - On that handshake: set last=id and go to IDLE.
- eng_done outside WAIT is ignored.
- req_ready is 0 outside IDLE. Requests are never dropped; they stay pending until accepted.
- Requests arriving while busy wait; no queuing beyond the single in-flight job.
- Reset mid-operation aborts everything with no response; a later eng_done from the aborted job is ignored.

## Timing
- Reset values:
  - State IDLE; last=NREQ-1, so requester 0 has first priority.
  - eng_start=0; eng_a=eng_b=0.
  - rsp_valid=0, rsp_id=0, rsp_gcd=0, rsp_inv=0, rsp_err=0.
  - busy=0; req_ready=0.
- Accept in cycle T:
  - eng_start is high in T+1.
  - WAIT starts in T+2.
  - If eng_done arrives in cycle D ≥ T+2, rsp_valid is high from D+1.
- Zero-operand path: rsp_valid is high from T+1; eng_start is never asserted.
- Timeout path: WAIT lasts TIMEOUT cycles; rsp_valid is high from T+2+TIMEOUT.
- eng_done in the same cycle as timer==TIMEOUT-1: done wins and the result is valid.
- Next acceptance is no earlier than the cycle after the response handshake. Minimum period between accepts is 4 cycles with done at T+2 and rsp_ready held high.
- Width rules: the timer is ceil(log2(TIMEOUT)) bits wide and never wraps. The selection pointer wraps modulo NREQ.

## Test plan
- Single request: req0 a=3, b=7; engine model returns done 5 cycles after start with gcd=1, inv=5 -> rsp_id=0, gcd=1, inv=5, err=0; rsp_valid exactly 1 cycle after done.
- Non-coprime operands: a=6, b=9; model returns gcd=3 -> rsp_gcd=3, inv=0, err=1.
- Zero operand: a=0, b=5 -> no eng_start; rsp_valid at T+1 with gcd=5, err=1, inv=0.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 -> accept order 0,1,2,3,0; each req_ready is a single-cycle one-hot pulse.
- Timeout and backpressure: TIMEOUT=8, engine never done -> rsp_valid at T+10 with err=1. With rsp_ready low for 5 cycles, the response stays stable and no new request is accepted.
- Mid-job reset: assert rst_n=0 during WAIT -> all outputs at reset values immediately. A stale eng_done after reset release produces no response. The next request is served starting from requester 0.
